// File: rtl/i2ss_rx_if.sv
// Sample-pair delivery bundle from the I2S receiver toward the downstream fifo.
interface i2ss_rx_if #(
  parameter int unsigned DW = 24
);
  logic          o_valid;
  logic          i_ready;
  logic [DW-1:0] l_sample;
  logic [DW-1:0] r_sample;
  logic          locked;
  logic          overflow;

  modport master (
    output o_valid, l_sample, r_sample, locked, overflow,
    input  i_ready
  );

  modport slave (
    input  o_valid, l_sample, r_sample, locked, overflow,
    output i_ready
  );
endinterface

// File: rtl/i2ss_rx.sv
// I2S slave receiver: oversamples sclk/lrclk/sdata on mclk and delivers MSB-aligned
// left/right pairs on a valid/ready interface.
module i2ss_rx #(
  parameter int unsigned DW = 24
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      sclk,
  input  logic      lrclk,
  input  logic      sdata,
  i2ss_rx_if.master bus
);
  localparam int unsigned CW = $clog2(DW + 1);

  typedef enum logic [1:0] {StAlign, StLeft, StRight} state_e;

  logic          r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic          r_lr_s1, r_lr_s2, r_sd_s1, r_sd_s2;
  logic          r_lr_prev, r_lr_prev_d;
  logic [DW-1:0] r_shift, r_shift_d;
  logic [CW-1:0] r_cnt, r_cnt_d;
  state_e        r_state, r_state_d;
  logic [DW-1:0] r_l_hold, r_l_hold_d;
  logic          r_valid, r_valid_d;
  logic [DW-1:0] r_l, r_l_d, r_r, r_r_d;
  logic          r_locked, r_locked_d;
  logic          r_ovf, r_ovf_d;

  logic          w_rise, w_chg, w_do_shift, w_pair;
  logic [DW-1:0] w_shifted, w_word;
  logic [CW-1:0] w_cnt_inc;

  assign w_rise     = r_sclk_s2 & ~r_sclk_s3;
  assign w_chg      = r_lr_s2 ^ r_lr_prev;
  assign w_do_shift = r_cnt < CW'(DW);
  assign w_shifted  = w_do_shift ? {r_shift[DW-2:0], r_sd_s2} : r_shift;
  assign w_cnt_inc  = w_do_shift ? r_cnt + CW'(1) : r_cnt;
  // Short slots are MSB-aligned; an empty slot (change on back-to-back rises) yields zero.
  assign w_word     = (r_cnt == '0) ? '0 : (w_shifted << (CW'(DW) - w_cnt_inc));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_s3 <= 1'b0;
      r_lr_s1   <= 1'b0;
      r_lr_s2   <= 1'b0;
      r_sd_s1   <= 1'b0;
      r_sd_s2   <= 1'b0;
      r_lr_prev <= 1'b0;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_state   <= StAlign;
      r_l_hold  <= '0;
      r_valid   <= 1'b0;
      r_l       <= '0;
      r_r       <= '0;
      r_locked  <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_sclk_s1 <= sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_lr_s1   <= lrclk;
      r_lr_s2   <= r_lr_s1;
      r_sd_s1   <= sdata;
      r_sd_s2   <= r_sd_s1;
      r_lr_prev <= r_lr_prev_d;
      r_shift   <= r_shift_d;
      r_cnt     <= r_cnt_d;
      r_state   <= r_state_d;
      r_l_hold  <= r_l_hold_d;
      r_valid   <= r_valid_d;
      r_l       <= r_l_d;
      r_r       <= r_r_d;
      r_locked  <= r_locked_d;
      r_ovf     <= r_ovf_d;
    end
  end

  always_comb begin
    r_lr_prev_d = r_lr_prev;
    r_shift_d   = r_shift;
    r_cnt_d     = r_cnt;
    r_state_d   = r_state;
    r_l_hold_d  = r_l_hold;
    r_valid_d   = r_valid & ~bus.i_ready;
    r_l_d       = r_l;
    r_r_d       = r_r;
    r_locked_d  = r_locked;
    r_ovf_d     = r_ovf;
    w_pair      = 1'b0;

    if (w_rise) begin
      r_lr_prev_d = r_lr_s2;
      r_shift_d   = w_shifted;
      r_cnt_d     = w_cnt_inc;
      if (w_chg) begin
        r_shift_d = '0;
        r_cnt_d   = '0;
        unique case (r_state)
          StAlign: begin
            if (!r_lr_s2) begin
              r_state_d  = StLeft;
              r_locked_d = 1'b1;
            end
          end
          StLeft: begin
            if (r_lr_s2) begin
              r_l_hold_d = w_word;
              r_state_d  = StRight;
            end
          end
          StRight: begin
            if (!r_lr_s2) begin
              w_pair    = 1'b1;
              r_state_d = StLeft;
            end
          end
          default: r_state_d = StAlign;
        endcase
      end
    end

    // A pair that finds the output still occupied and not draining is dropped.
    if (w_pair) begin
      if (r_valid && !bus.i_ready) begin
        r_ovf_d = 1'b1;
      end else begin
        r_valid_d = 1'b1;
        r_l_d     = r_l_hold;
        r_r_d     = w_word;
      end
    end
  end

  assign bus.o_valid  = r_valid;
  assign bus.l_sample = r_l;
  assign bus.r_sample = r_r;
  assign bus.locked   = r_locked;
  assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_i2ss_rx.sv
// Randomised bench for i2ss_rx: drives I2S frames and compares delivered pairs against
// a frame-level model of alignment, MSB alignment and drop rules.
module tb_i2ss_rx;
  logic clk = 1'b0;
  logic rst_n, sclk, lrclk, sdata;
  int   n_pass = 0;
  int   n_total = 0;
  bit   m_locked;
  logic [47:0] exp_q[$];
  logic [47:0] rcv_q[$];

  i2ss_rx_if #(.DW(24)) bus ();

  i2ss_rx #(.DW(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sclk  (sclk),
    .lrclk (lrclk),
    .sdata (sdata),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && bus.o_valid && bus.i_ready) rcv_q.push_back({bus.l_sample, bus.r_sample});
  end

  function automatic logic [23:0] exp_sample(input logic [31:0] w, input int sw);
    logic [31:0] m;
    m = (sw == 32) ? w : (w & ((32'd1 << sw) - 32'd1));
    if (sw >= 24) return 24'(m >> (sw - 24));
    return 24'(m << (24 - sw));
  endfunction

  task automatic do_reset(input logic rdy);
    rst_n = 1'b0; sclk = 1'b0; lrclk = 1'b0; sdata = 1'b0; bus.i_ready = rdy;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete(); rcv_q.delete(); m_locked = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // lrclk leads data by one bit; the final bit of the right slot already sees left.
  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int sw,
                            input int h, input int nbits);
    for (int b = 0; b < nbits; b++) begin
      sclk  = 1'b0;
      sdata = (b < sw) ? l[sw-1-b] : r[2*sw-1-b];
      lrclk = (b + 1 >= sw) && (b + 1 < 2 * sw);
      repeat (h) @(posedge clk);
      #1 sclk = 1'b1;
      repeat (h) @(posedge clk);
      #1;
    end
    if (nbits == 2 * sw) begin
      if (m_locked) exp_q.push_back({exp_sample(l, sw), exp_sample(r, sw)});
      m_locked = 1'b1;
    end
  endtask

  task automatic test_reset;
    do_reset(1'b1);
    n_total += 5;
    if (bus.o_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.o_valid);
    else n_pass++;
    if (bus.locked !== 1'b0) $display("FAIL reset_locked got %b want 0", bus.locked);
    else n_pass++;
    if (bus.overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", bus.overflow);
    else n_pass++;
    if (bus.l_sample !== 24'h0) $display("FAIL reset_l got %h want 0", bus.l_sample);
    else n_pass++;
    if (bus.r_sample !== 24'h0) $display("FAIL reset_r got %h want 0", bus.r_sample);
    else n_pass++;
  endtask

  task automatic test_slots(input string name, input int sw, input int h, input int nfr,
                            input logic [31:0] l0, input logic [31:0] r0);
    do_reset(1'b1);
    send_frame(l0, r0, sw, h, 2 * sw);
    repeat (6) @(posedge clk);
    #1;
    n_total++;
    if (bus.locked !== 1'b1 || rcv_q.size() != 0)
      $display("FAIL %s_lock locked %b pairs %0d want 1 and 0", name, bus.locked, rcv_q.size());
    else n_pass++;
    send_frame(l0, r0, sw, h, 2 * sw);
    for (int f = 1; f < nfr; f++) send_frame($urandom, $urandom, sw, h, 2 * sw);
    repeat (6) @(posedge clk);
    #1;
    n_total++;
    if (rcv_q.size() != exp_q.size())
      $display("FAIL %s_count got %0d want %0d", name, rcv_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
      n_total++;
      if (rcv_q[i] !== exp_q[i]) $display("FAIL %s_pair%0d got %h want %h", name, i, rcv_q[i],
                                          exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] l1, r1;
    l1 = $urandom; r1 = $urandom;
    do_reset(1'b0);
    send_frame($urandom, $urandom, 32, 2, 64);
    send_frame(l1, r1, 32, 2, 64);
    repeat (4) @(posedge clk);
    #1;
    n_total += 2;
    if (bus.o_valid !== 1'b1) $display("FAIL bp_valid got %b want 1", bus.o_valid);
    else n_pass++;
    if ({bus.l_sample, bus.r_sample} !== exp_q[0])
      $display("FAIL bp_p1 got %h want %h", {bus.l_sample, bus.r_sample}, exp_q[0]);
    else n_pass++;
    send_frame($urandom, $urandom, 32, 2, 64);
    void'(exp_q.pop_back());
    repeat (4) @(posedge clk);
    #1;
    n_total += 2;
    if ({bus.o_valid, bus.overflow} !== 2'b11)
      $display("FAIL bp_ovf got %b want 11", {bus.o_valid, bus.overflow});
    else n_pass++;
    if ({bus.l_sample, bus.r_sample} !== exp_q[0])
      $display("FAIL bp_hold got %h want %h", {bus.l_sample, bus.r_sample}, exp_q[0]);
    else n_pass++;
    bus.i_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send_frame($urandom, $urandom, 32, 2, 64);
    repeat (6) @(posedge clk);
    #1;
    n_total += 2;
    if (bus.overflow !== 1'b1) $display("FAIL bp_sticky got %b want 1", bus.overflow);
    else n_pass++;
    if (rcv_q.size() != 2) $display("FAIL bp_count got %0d want 2", rcv_q.size());
    else n_pass++;
    for (int i = 0; i < 2 && i < rcv_q.size(); i++) begin
      n_total++;
      if (rcv_q[i] !== exp_q[i]) $display("FAIL bp_pair%0d got %h want %h", i, rcv_q[i],
                                          exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    do_reset(1'b1);
    send_frame($urandom, $urandom, 32, 2, 64);
    send_frame($urandom | 32'h0100_0000, $urandom | 32'h0100_0000, 32, 2, 64);
    repeat (6) @(posedge clk);
    #1;
    n_total++;
    if (rcv_q.size() != 1 || rcv_q[0] !== exp_q[0])
      $display("FAIL rm_pre got %0d pairs want 1 of %h", rcv_q.size(), exp_q[0]);
    else n_pass++;
    send_frame($urandom, $urandom, 32, 2, 10);
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus.o_valid, bus.locked, bus.l_sample, bus.r_sample} !== 50'h0)
      $display("FAIL rm_async got v%b k%b l%h r%h want all 0", bus.o_valid, bus.locked,
               bus.l_sample, bus.r_sample);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete(); rcv_q.delete(); m_locked = 1'b0;
    send_frame($urandom, $urandom, 32, 2, 64);
    repeat (6) @(posedge clk);
    #1;
    n_total++;
    if (rcv_q.size() != 0) $display("FAIL rm_early got %0d pairs want 0", rcv_q.size());
    else n_pass++;
    send_frame($urandom, $urandom, 32, 2, 64);
    repeat (6) @(posedge clk);
    #1;
    n_total++;
    if (rcv_q.size() != 1 || rcv_q[0] !== exp_q[0])
      $display("FAIL rm_post got %0d pairs want 1 of %h", rcv_q.size(), exp_q[0]);
    else n_pass++;
  endtask

  // Release the pending pair on the same edge the next pair completes.
  task automatic test_back_to_back;
    do_reset(1'b0);
    send_frame($urandom, $urandom, 32, 2, 64);
    send_frame($urandom, $urandom, 32, 2, 64);
    repeat (4) @(posedge clk);
    #1;
    send_frame($urandom, $urandom, 32, 2, 64);
    bus.i_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_total += 2;
    if ({bus.overflow, bus.o_valid} !== 2'b00)
      $display("FAIL b2b_flags got ovf%b v%b want 00", bus.overflow, bus.o_valid);
    else n_pass++;
    if (rcv_q.size() != 2) $display("FAIL b2b_count got %0d want 2", rcv_q.size());
    else n_pass++;
    for (int i = 0; i < 2 && i < rcv_q.size(); i++) begin
      n_total++;
      if (rcv_q[i] !== exp_q[i]) $display("FAIL b2b_pair%0d got %h want %h", i, rcv_q[i],
                                          exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_ready_toggle;
    bit done;
    done = 1'b0;
    do_reset(1'b1);
    fork
      begin
        for (int f = 0; f < 5; f++) send_frame($urandom, $urandom, 32, 2, 64);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 bus.i_ready = ~bus.i_ready;
        end
      end
    join
    bus.i_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_total += 2;
    if (bus.overflow !== 1'b0) $display("FAIL tog_ovf got %b want 0", bus.overflow);
    else n_pass++;
    if (rcv_q.size() != exp_q.size())
      $display("FAIL tog_count got %0d want %0d", rcv_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < rcv_q.size(); i++) begin
      n_total++;
      if (rcv_q[i] !== exp_q[i]) $display("FAIL tog_pair%0d got %h want %h", i, rcv_q[i],
                                          exp_q[i]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_slots("s32", 32, 2, 5, 32'h1234_5600, 32'hABCD_EF00);
    test_slots("s16", 16, 4, 4, 32'h0000_8001, 32'h0000_7FFF);
    test_slots("s24", 24, 3, 8, 32'h00FF_FFFF, 32'h0000_0001);
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_ready_toggle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/i2ss_rx.md
Name: i2ss_rx

Overview:
- I2S slave receiver running on the 12.288 MHz mclk domain; the other end of the I2S link from the master transmitter.
- Oversamples external sclk/lrclk/sdata driven by a codec ADC or external master.
- Deserialises MSB-first I2S frames (one-bit delay after the lrclk edge) into left/right sample pairs.
- Presents each pair on a valid/ready interface that feeds the async fifo toward the framework bus.

Parameters:
- DW, 24, sample width delivered per channel. Slot bits beyond DW are ignored; short slots are zero-padded at the LSBs.

Ports:
- clk  input  1  mclk, 12.288 MHz; sole clock.
- rst_n  input  1  reset; asynchronous, active-low.
- sclk  input  1  I2S bit clock, asynchronous to clk; frequency ≤ clk/4.
- lrclk  input  1  I2S word select, asynchronous; 0 = left, 1 = right.
- sdata  input  1  I2S serial data; changes on sclk falling edge.
- o_valid  output  1  l_sample/r_sample hold a complete pair.
- i_ready  input  1  downstream (fifo not full) accepts the pair.
- l_sample  output  DW  left sample, two's complement, MSB-aligned.
- r_sample  output  DW  right sample, MSB-aligned.
- locked  output  1  receiver aligned to frame boundaries.
- overflow  output  1  sticky flag: a completed pair was dropped.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n low, async assert, sync release through the flops):
  - o_valid, locked, overflow = 0.
  - l_sample, r_sample = 0.
  - Synchroniser flops, shift register and bit counter = 0.
  - State = ALIGN.
- Input capture:
  - sclk, lrclk and sdata each pass through a 2-flop synchroniser (s1, s2).
  - sclk has a third flop s3; rise = s2 & !s3.
  - All decisions are made only in rise cycles, using s2 of lrclk/sdata.
  - lr_prev is a register updated with lrclk s2 on every rise.
  - lr_chg = (lrclk s2 != lr_prev).
- Per rise:
  - If bit_cnt < DW: shift sdata into shift_r LSB; bit_cnt++ (saturates at DW).
  - If lr_chg: this rise carries the LSB slot of the ending word.
    - Word value = shift_r after this shift, left-shifted by DW − bit_cnt.
    - bit_cnt and shift_r are cleared for the new word. The MSB of the new word arrives on the next rise.
- States:
  - ALIGN: discard all data. On the first lr_chg with lrclk s2 = 0 (right→left), go to LEFT and set locked = 1. A 0→1 change stays in ALIGN.
  - LEFT: at lr_chg (lrclk now 1), latch the word into l_hold and go to RIGHT.
  - RIGHT: at lr_chg (lrclk now 0), register l_sample = l_hold and r_sample = word, set o_valid = 1, and go to LEFT.
- Latency: o_valid asserts at the clk edge two cycles after the edge that first registers sclk high at s1 for the final-bit rise (3 clk edges total).
- Handshake:
  - Transfer occurs when o_valid & i_ready; o_valid clears the next cycle.
  - While o_valid & !i_ready, the outputs are held stable.
  - If a new pair completes while o_valid is high and not transferring, the new pair is dropped, the held pair is kept, and overflow is set. overflow stays set until reset.
  - Transfer and new-pair completion in the same cycle: the new pair loads and o_valid stays 1 with no overflow.
- Simultaneous lr_chg and bit_cnt = DW: the shift is skipped, the word is still finalised, and nothing is lost.
- Zero-length slot (lr_chg on two consecutive rises): the word is finalised as 0.
- rst_n asserted mid-frame: everything returns to ALIGN. The first pair after release is the first complete left+right frame.

Test Plan:
- Setup for all scenarios: DW=24, sclk = clk/4 (64 fs, 32-bit slots).
- Reset, then 3 frames L=0x123456_00pad / R=0xABCDEF, i_ready=1 → first frame dropped during ALIGN if entered mid-left; then o_valid pulses one cycle per frame with l=0x123456, r=0xABCDEF; locked=1 after the first right→left edge.
- 16-bit slots (sclk = 32 fs = clk/8) with L=0x8001, R=0x7FFF → l_sample=0x800100, r_sample=0x7FFF00.
- 24-bit slots (48 fs) with L=0xFFFFFF, R=0x000001 → LSB taken on the lr_chg rise; l=0xFFFFFF, r=0x000001; no bit slip across 8 frames.
- i_ready=0 for 2 frames (pairs P1, P2) → o_valid held with P1 constant, P2 dropped, overflow=1; raising i_ready transfers P1, and P3 arrives normally.
- rst_n pulsed low mid-left word → outputs zero immediately (async); after release, no o_valid until one full left+right frame; that pair is correct.
- i_ready toggled 1/0 each cycle with a pair completing on the accept cycle → no overflow, each pair delivered exactly once.
